// File: rtl/mem_iq_slot_array_pkg.sv
// ---------------------------------------------------------------------------
// falco_pkg
// Shared types and sizes for the memory issue queue.
//   mem_iq_entry_t : dispatched load/store micro-op as held in a slot
//   tag_woken()    : true when a source tag is the zero register or matches
//                    any valid writeback broadcast this cycle
// ---------------------------------------------------------------------------
package falco_pkg;

   localparam int MEM_IQ_NUM   = 8;
   localparam int MEM_IQ_WIDTH = 3;
   localparam int PRF_WIDTH    = 6;
   localparam int ROB_WIDTH    = 5;
   localparam int WB_PORTS     = 2;
   localparam int IMM_WIDTH    = 12;
   localparam int FUNC_WIDTH   = 4;

   typedef struct packed {
      logic [PRF_WIDTH-1:0]  rs1_tag;
      logic                  rs1_rdy;
      logic [PRF_WIDTH-1:0]  rs2_tag;
      logic                  rs2_rdy;
      logic                  is_store;
      logic [ROB_WIDTH-1:0]  rob_idx;
      logic [IMM_WIDTH-1:0]  imm;
      logic [FUNC_WIDTH-1:0] func;
   } mem_iq_entry_t;

   function automatic logic tag_woken(
      input logic [PRF_WIDTH-1:0]               tag,
      input logic [WB_PORTS-1:0]                wb_valid,
      input logic [WB_PORTS-1:0][PRF_WIDTH-1:0] wb_tag
   );
      logic hit;
      hit = (tag == '0);  // physical register 0 is hardwired zero
      for (int p = 0; p < WB_PORTS; p++) begin
         if (wb_valid[p] && (wb_tag[p] == tag)) hit = 1'b1;
      end
      return hit;
   endfunction

endpackage

// File: rtl/mem_iq_slot_array_free_slot_finder.sv
// ---------------------------------------------------------------------------
// mem_iq_free_slot_finder
// Lowest-index free-slot priority encoder over the slot valid vector.
//   valid    in  per-slot occupied bits
//   free_idx out lowest index with valid=0 (0 when none)
//   any_free out at least one slot is free
// ---------------------------------------------------------------------------
module mem_iq_free_slot_finder
   import falco_pkg::*;
(
   input  logic [MEM_IQ_NUM-1:0]   valid,
   output logic [MEM_IQ_WIDTH-1:0] free_idx,
   output logic                    any_free
);

   always_comb begin
      // NOTE: every output gets a default before the loop so no path leaves it
      // unassigned; otherwise synthesis infers a latch.
      free_idx = '0;
      any_free = 1'b0;
      // Walk downward so the lowest free index is the last one written.
      for (int i = MEM_IQ_NUM - 1; i >= 0; i--) begin
         if (!valid[i]) begin
            free_idx = MEM_IQ_WIDTH'(i);
            any_free = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_iq_slot_array.sv
// ---------------------------------------------------------------------------
// mem_iq_slot_array
// 8-entry storage array of the memory issue queue. Captures dispatched
// load/store micro-ops, wakes their sources on writeback, exports a per-slot
// ready vector to the selector, and launches the granted slot into a
// registered issue latch for the AGU/LSU.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset (beats flush)
//   flush                 drop every slot and the issue latch
//   disp_valid/ready/entry  dispatch handshake and micro-op
//   wb_valid, wb_tag      writeback wakeup broadcasts
//   issue_ready           per-slot selectable vector (registers only)
//   issue_lock            blocks selector grants (iss_stall | flush)
//   issue_slot_idx(_valid) grant from the selector
//   iss_valid, iss_entry  issue latch towards AGU/LSU
//   iss_stall             downstream back-pressure; holds the latch
//   iq_count              occupied slots, 0..8
//
// Build option: define MEM_IQ_SDA_GATE_EN to add input mem_sda_full, which
// masks stores out of issue_ready while the store-data buffer is full.
// ---------------------------------------------------------------------------
module mem_iq_slot_array
   import falco_pkg::*;
(
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               flush,
   input  logic                               disp_valid,
   output logic                               disp_ready,
   input  mem_iq_entry_t                      disp_entry,
   input  logic [WB_PORTS-1:0]                wb_valid,
   input  logic [WB_PORTS-1:0][PRF_WIDTH-1:0] wb_tag,
   output logic [MEM_IQ_NUM-1:0]              issue_ready,
   output logic                               issue_lock,
   input  logic [MEM_IQ_WIDTH-1:0]            issue_slot_idx,
   input  logic                               issue_slot_idx_valid,
   output logic                               iss_valid,
   output mem_iq_entry_t                      iss_entry,
   input  logic                               iss_stall,
`ifdef MEM_IQ_SDA_GATE_EN
   input  logic                               mem_sda_full,
`endif
   output logic [3:0]                         iq_count
);

   logic [MEM_IQ_NUM-1:0]   valid;
   mem_iq_entry_t           slot [MEM_IQ_NUM];
   logic [MEM_IQ_WIDTH-1:0] free_idx;
   logic                    any_free;
   logic                    alloc;
   logic                    issue_fire;
   mem_iq_entry_t           disp_write;

   mem_iq_free_slot_finder u_free_slot_finder (
      .valid    (valid),
      .free_idx (free_idx),
      .any_free (any_free)
   );

   assign disp_ready = (iq_count != 4'(MEM_IQ_NUM)) & ~flush;
   assign alloc      = disp_valid & disp_ready & any_free;
   assign issue_lock = iss_stall | flush;

   // Grants to unselectable slots, or while the latch is held, are dropped.
   assign issue_fire = issue_slot_idx_valid & ~iss_stall & issue_ready[issue_slot_idx];

   always_comb begin
      issue_ready = '0;
      for (int i = 0; i < MEM_IQ_NUM; i++) begin
         issue_ready[i] = valid[i] & slot[i].rs1_rdy & slot[i].rs2_rdy;
`ifdef MEM_IQ_SDA_GATE_EN
         issue_ready[i] = issue_ready[i] & ~(slot[i].is_store & mem_sda_full);
`endif
      end
   end

   // Dispatch bypass: sources produced this very cycle enter already ready.
   always_comb begin
      disp_write         = disp_entry;
      disp_write.rs1_rdy = disp_entry.rs1_rdy | tag_woken(disp_entry.rs1_tag, wb_valid, wb_tag);
      disp_write.rs2_rdy = disp_entry.rs2_rdy | tag_woken(disp_entry.rs2_tag, wb_valid, wb_tag);
   end

   // NOTE: slot payloads carry no reset; they are only observed behind their
   // valid bit, which is reset, so a reset here would only add fan-out.
   always_ff @(posedge clk) begin
      for (int i = 0; i < MEM_IQ_NUM; i++) begin
         if (alloc && (free_idx == MEM_IQ_WIDTH'(i))) begin
            slot[i] <= disp_write;
         end else if (valid[i]) begin
            if (tag_woken(slot[i].rs1_tag, wb_valid, wb_tag)) slot[i].rs1_rdy <= 1'b1;
            if (tag_woken(slot[i].rs2_tag, wb_valid, wb_tag)) slot[i].rs2_rdy <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state uses non-blocking assignments so every register samples
      // the pre-edge values, independent of statement order.
      if (rst || flush) begin
         valid     <= '0;
         iq_count  <= '0;
         iss_valid <= 1'b0;
         iss_entry <= '0;
      end else begin
         // The issued slot is still valid this cycle, so it can never be the
         // allocation target; both updates may safely coexist.
         if (issue_fire) valid[issue_slot_idx] <= 1'b0;
         if (alloc)      valid[free_idx]       <= 1'b1;
         iq_count <= iq_count + 4'(alloc) - 4'(issue_fire);

         if (issue_fire) begin
            iss_valid <= 1'b1;
            iss_entry <= slot[issue_slot_idx];
         end else if (!iss_stall) begin
            iss_valid <= 1'b0;
         end
      end
   end

   a_grant_legal: assert property (@(posedge clk) disable iff (rst)
      (issue_slot_idx_valid && !iss_stall && !flush) |-> issue_ready[issue_slot_idx]);

endmodule

// File: tb/tb_mem_iq_slot_array.sv
// ---------------------------------------------------------------------------
// tb_mem_iq_slot_array
// Self-checking bench for mem_iq_slot_array: directed scenarios with literal
// expectations followed by randomized traffic compared every cycle against
// an array-based reference model of the queue.
// ---------------------------------------------------------------------------
module tb_mem_iq_slot_array;
   import falco_pkg::*;

   logic                               clk = 1'b0;
   logic                               rst;
   logic                               flush;
   logic                               disp_valid;
   logic                               disp_ready;
   mem_iq_entry_t                      disp_entry;
   logic [WB_PORTS-1:0]                wb_valid;
   logic [WB_PORTS-1:0][PRF_WIDTH-1:0] wb_tag;
   logic [MEM_IQ_NUM-1:0]              issue_ready;
   logic                               issue_lock;
   logic [MEM_IQ_WIDTH-1:0]            issue_slot_idx;
   logic                               issue_slot_idx_valid;
   logic                               iss_valid;
   mem_iq_entry_t                      iss_entry;
   logic                               iss_stall;
   logic [3:0]                         iq_count;
`ifdef MEM_IQ_SDA_GATE_EN
   logic                               mem_sda_full;
`endif

   mem_iq_slot_array dut (
      .clk                  (clk),
      .rst                  (rst),
      .flush                (flush),
      .disp_valid           (disp_valid),
      .disp_ready           (disp_ready),
      .disp_entry           (disp_entry),
      .wb_valid             (wb_valid),
      .wb_tag               (wb_tag),
      .issue_ready          (issue_ready),
      .issue_lock           (issue_lock),
      .issue_slot_idx       (issue_slot_idx),
      .issue_slot_idx_valid (issue_slot_idx_valid),
      .iss_valid            (iss_valid),
      .iss_entry            (iss_entry),
      .iss_stall            (iss_stall),
`ifdef MEM_IQ_SDA_GATE_EN
      .mem_sda_full         (mem_sda_full),
`endif
      .iq_count             (iq_count)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   bit            m_valid [MEM_IQ_NUM];
   mem_iq_entry_t m_ent   [MEM_IQ_NUM];
   bit            m_iss_valid;
   mem_iq_entry_t m_iss;
   bit            m_live = 1'b0;

   function automatic bit woken(input logic [PRF_WIDTH-1:0] tag);
      if (tag == 0) return 1'b1;
      for (int p = 0; p < WB_PORTS; p++)
         if (wb_valid[p] && wb_tag[p] == tag) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit m_ready(input int i);
      bit r;
      r = m_valid[i] && m_ent[i].rs1_rdy && m_ent[i].rs2_rdy;
`ifdef MEM_IQ_SDA_GATE_EN
      if (m_ent[i].is_store && mem_sda_full) r = 1'b0;
`endif
      return r;
   endfunction

   function automatic int m_count();
      int n = 0;
      for (int i = 0; i < MEM_IQ_NUM; i++) n += int'(m_valid[i]);
      return n;
   endfunction

   task automatic m_clear();
      for (int i = 0; i < MEM_IQ_NUM; i++) m_valid[i] = 1'b0;
      m_iss_valid = 1'b0;
      m_iss       = '0;
   endtask

   always @(posedge clk) begin : model_update
      bit            gv;
      int            gi;
      int            fi;
      mem_iq_entry_t e;
      if (rst) begin
         m_clear();
         m_live = 1'b1;
      end else if (m_live) begin
         if (flush) begin
            m_clear();
         end else begin
            gi = int'(issue_slot_idx);
            gv = issue_slot_idx_valid && !iss_stall && m_ready(gi);
            fi = -1;
            if (disp_valid && m_count() < MEM_IQ_NUM)
               for (int i = MEM_IQ_NUM - 1; i >= 0; i--) if (!m_valid[i]) fi = i;
            if (gv) begin
               m_iss_valid = 1'b1;
               m_iss       = m_ent[gi];
            end else if (!iss_stall) begin
               m_iss_valid = 1'b0;
            end
            for (int i = 0; i < MEM_IQ_NUM; i++) begin
               if (m_valid[i]) begin
                  if (woken(m_ent[i].rs1_tag)) m_ent[i].rs1_rdy = 1'b1;
                  if (woken(m_ent[i].rs2_tag)) m_ent[i].rs2_rdy = 1'b1;
               end
            end
            if (gv) m_valid[gi] = 1'b0;
            if (fi >= 0) begin
               e = disp_entry;
               if (woken(e.rs1_tag)) e.rs1_rdy = 1'b1;
               if (woken(e.rs2_tag)) e.rs2_rdy = 1'b1;
               m_ent[fi]   = e;
               m_valid[fi] = 1'b1;
            end
         end
      end
   end

   // Single compare process, mid-cycle, every cycle after reset.
   always @(negedge clk) begin : compare
      logic [MEM_IQ_NUM-1:0] er;
      if (m_live && !rst) begin
         for (int i = 0; i < MEM_IQ_NUM; i++) er[i] = m_ready(i);
         check("issue_ready", 64'(issue_ready), 64'(er));
         check("iq_count",    64'(iq_count),    64'(m_count()));
         check("disp_ready",  64'(disp_ready),  64'(m_count() != MEM_IQ_NUM && !flush));
         check("issue_lock",  64'(issue_lock),  64'(iss_stall || flush));
         check("iss_valid",   64'(iss_valid),   64'(m_iss_valid));
         if (m_iss_valid) check("iss_entry", 64'(iss_entry), 64'(m_iss));
      end
   end

   // ---------------- stimulus ----------------
   task automatic idle();
      flush                = 1'b0;
      disp_valid           = 1'b0;
      disp_entry           = '0;
      wb_valid             = '0;
      wb_tag               = '0;
      issue_slot_idx       = '0;
      issue_slot_idx_valid = 1'b0;
      iss_stall            = 1'b0;
`ifdef MEM_IQ_SDA_GATE_EN
      mem_sda_full         = 1'b0;
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic mem_iq_entry_t mk(input int r1t, input bit r1, input int r2t,
                                        input bit r2, input bit st, input int rob);
      mem_iq_entry_t e;
      e.rs1_tag  = PRF_WIDTH'(r1t);
      e.rs1_rdy  = r1;
      e.rs2_tag  = PRF_WIDTH'(r2t);
      e.rs2_rdy  = r2;
      e.is_store = st;
      e.rob_idx  = ROB_WIDTH'(rob);
      e.imm      = IMM_WIDTH'($urandom);
      e.func     = FUNC_WIDTH'($urandom);
      return e;
   endfunction

   mem_iq_entry_t exp_e [MEM_IQ_NUM];
   int            ready_list [$];

   initial begin
      idle();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
      check("rst_iq_count",    64'(iq_count),    64'd0);
      check("rst_iss_valid",   64'(iss_valid),   64'd0);
      check("rst_iss_entry",   64'(iss_entry),   64'd0);
      check("rst_issue_ready", 64'(issue_ready), 64'd0);
      check("rst_disp_ready",  64'(disp_ready),  64'd1);

      // Fill all eight slots in order.
      for (int k = 0; k < MEM_IQ_NUM; k++) begin
         exp_e[k]   = mk(k + 1, 1'b1, k + 9, 1'b1, k[0], k);
         disp_valid = 1'b1;
         disp_entry = exp_e[k];
         tick();
         check("fill_order", 64'(issue_ready), 64'((1 << (k + 1)) - 1));
      end
      idle();
      #1;
      check("full_count",      64'(iq_count),   64'd8);
      check("full_disp_ready", 64'(disp_ready), 64'd0);

      // Grant slot 3, then stall the latch for two cycles.
      issue_slot_idx       = 3'd3;
      issue_slot_idx_valid = 1'b1;
      tick();
      issue_slot_idx_valid = 1'b0;
      iss_stall            = 1'b1;
      #1;
      check("g3_iss_valid1", 64'(iss_valid),   64'd1);
      check("g3_entry1",     64'(iss_entry),   64'(exp_e[3]));
      check("g3_lock1",      64'(issue_lock),  64'd1);
      check("g3_freed",      64'(issue_ready), 64'hF7);
      check("g3_count",      64'(iq_count),    64'd7);
      tick();
      check("g3_iss_valid2", 64'(iss_valid),   64'd1);
      check("g3_entry2",     64'(iss_entry),   64'(exp_e[3]));
      check("g3_lock2",      64'(issue_lock),  64'd1);
      tick();
      iss_stall = 1'b0;
      #1;
      check("g3_iss_valid3", 64'(iss_valid),   64'd1);
      check("g3_entry3",     64'(iss_entry),   64'(exp_e[3]));
      check("g3_lock3",      64'(issue_lock),  64'd0);
      tick();
      check("g3_drop",       64'(iss_valid),   64'd0);

      // Refill slot 3.
      disp_valid = 1'b1;
      disp_entry = mk(20, 1'b1, 21, 1'b1, 1'b0, 20);
      tick();
      check("refill_count", 64'(iq_count), 64'd8);

      // Full queue: grant slot 5 and dispatch in the same cycle.
      disp_entry           = mk(22, 1'b1, 23, 1'b1, 1'b1, 21);
      issue_slot_idx       = 3'd5;
      issue_slot_idx_valid = 1'b1;
      #1;
      check("g5_no_alloc", 64'(disp_ready), 64'd0);
      tick();
      issue_slot_idx_valid = 1'b0;
      #1;
      check("g5_count7",      64'(iq_count),   64'd7);
      check("g5_ready_again", 64'(disp_ready), 64'd1);
      tick();
      disp_valid = 1'b0;
      check("g5_count8",   64'(iq_count),    64'd8);
      check("g5_realloc",  64'(issue_ready), 64'hFF);

      // Late wakeup on port 1.
      idle();
      flush = 1'b1;
      tick();
      flush      = 1'b0;
      disp_valid = 1'b1;
      disp_entry = mk(12, 1'b0, 0, 1'b0, 1'b0, 3);
      tick();
      disp_valid = 1'b0;
      check("wk_wait0", 64'(issue_ready[0]), 64'd0);
      tick();
      wb_valid  = 2'b10;
      wb_tag[1] = 6'd12;
      #1;
      check("wk_wait1", 64'(issue_ready[0]), 64'd0);
      tick();
      wb_valid = '0;
      check("wk_ready", 64'(issue_ready[0]), 64'd1);

      // Dispatch bypass on port 0 into slot 1 (a store).
      disp_valid = 1'b1;
      disp_entry = mk(0, 1'b1, 9, 1'b0, 1'b1, 4);
      wb_valid   = 2'b01;
      wb_tag[0]  = 6'd9;
      tick();
      idle();
      #1;
      check("bypass_ready", 64'(issue_ready[1:0]), 64'h3);
`ifdef MEM_IQ_SDA_GATE_EN
      mem_sda_full = 1'b1;
      #1;
      check("sda_mask", 64'(issue_ready[1:0]), 64'h1);
      mem_sda_full = 1'b0;
`endif

      // Flush with 5 valid entries, a held issue latch and a dispatch.
      flush = 1'b1;
      tick();
      flush = 1'b0;
      for (int k = 0; k < 6; k++) begin
         disp_valid = 1'b1;
         disp_entry = mk(30 + k, 1'b1, 40 + k, 1'b1, 1'b0, k);
         tick();
      end
      disp_valid           = 1'b0;
      issue_slot_idx       = 3'd0;
      issue_slot_idx_valid = 1'b1;
      tick();
      issue_slot_idx_valid = 1'b0;
      flush                = 1'b1;
      disp_valid           = 1'b1;
      iss_stall            = 1'b1;
      #1;
      check("pre_flush_count", 64'(iq_count),  64'd5);
      check("pre_flush_iss",   64'(iss_valid), 64'd1);
      tick();
      idle();
      #1;
      check("flush_count", 64'(iq_count),    64'd0);
      check("flush_iss",   64'(iss_valid),   64'd0);
      check("flush_ready", 64'(issue_ready), 64'd0);

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         flush      = ($urandom_range(63) == 0);
         iss_stall  = ($urandom_range(3) == 0);
         disp_valid = ($urandom_range(2) != 0);
         disp_entry = mk($urandom_range(11), 1'($urandom), $urandom_range(11),
                         1'($urandom), 1'($urandom), $urandom_range(31));
         wb_valid   = WB_PORTS'($urandom);
         for (int p = 0; p < WB_PORTS; p++) wb_tag[p] = PRF_WIDTH'($urandom_range(11));
`ifdef MEM_IQ_SDA_GATE_EN
         mem_sda_full = ($urandom_range(3) == 0);
`endif
         issue_slot_idx_valid = 1'b0;
         issue_slot_idx       = MEM_IQ_WIDTH'($urandom);
         if (!iss_stall && !flush && $urandom_range(3) != 0) begin
            ready_list.delete();
            for (int i = 0; i < MEM_IQ_NUM; i++) if (m_ready(i)) ready_list.push_back(i);
            if (ready_list.size() != 0) begin
               issue_slot_idx       = MEM_IQ_WIDTH'(ready_list[$urandom_range(ready_list.size() - 1)]);
               issue_slot_idx_valid = 1'b1;
            end
         end
         tick();
      end

      idle();
      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
